// File: rtl/sdp_bram_pipe.sv
// Simple-dual-port byte-masked RAM with 1..3 cycle read pipeline.
// Define SDP_BRAM_INIT_CLEAR_EN to zero the array after every reset.
`timescale 1ns/1ps
module sdp_bram_pipe #(
    parameter int DATA_WIDTH   = 128,
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    output logic                      init_done,
    input  logic                      ren,
    input  logic [ADDR_WIDTH-1:0]     raddr,
    output logic                      rvalid,
    output logic [DATA_WIDTH-1:0]     rdata,
    input  logic [DATA_WIDTH/8-1:0]   wen,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]     wdata
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 3 || (DATA_WIDTH % 8) != 0) begin : g_bad_cfg
            $error("sdp_bram_pipe: READ_LATENCY must be 1..3, DATA_WIDTH a multiple of 8");
        end
    endgenerate

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic                    w_init;
    logic                    w_clr;
    logic [ADDR_WIDTH-1:0]   w_clr_addr;

`ifdef SDP_BRAM_INIT_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_addr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clr_addr <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = (r_clr_addr == '1) ? S_DONE : S_CLEAR;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_init     = (r_state == S_DONE);
        w_clr      = (r_state == S_CLEAR);
        w_clr_addr = r_clr_addr;
    end
`else
    logic r_init;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_init <= 1'b0;
        end else begin
            r_init <= 1'b1;
        end
    end

    always_comb begin
        w_init     = r_init;
        w_clr      = 1'b0;
        w_clr_addr = '0;
    end
`endif

    assign init_done = w_init;

    // The clear sweep owns the write port until the array is usable
    logic [NB-1:0]           w_wr_be;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_data;

    always_comb begin
        w_wr_be   = w_clr ? '1 : (w_init ? wen : '0);
        w_wr_addr = w_clr ? w_clr_addr : waddr;
        w_wr_data = w_clr ? '0 : wdata;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (w_wr_be[b]) begin
                r_mem[w_wr_addr][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end
    end

    logic                    w_rd_issue;
    logic [DATA_WIDTH-1:0]   w_rd_old;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    always_comb begin
        w_rd_issue = w_init & ren;
        w_rd_old   = r_mem[raddr];
        w_rd_word  = w_rd_old;
        if (WRITE_FIRST != 0 && raddr == waddr) begin
            for (int b = 0; b < NB; b++) begin
                if (wen[b]) begin
                    w_rd_word[8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0]   r_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_vld;

    // Later stages only advance behind a valid so the output word holds
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_issue;
            if (w_rd_issue) begin
                r_data[0] <= w_rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign rvalid = r_vld[READ_LATENCY-1];
    assign rdata  = r_data[READ_LATENCY-1];

endmodule

// File: tb/tb_sdp_bram_pipe.sv
// Bench for sdp_bram_pipe: three latency/collision variants share stimulus
// and are checked every cycle against an array-level reference model.
`timescale 1ns/1ps
module tb_sdp_bram_pipe;
    localparam int DW    = 128;
    localparam int AW    = 4;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
`ifdef SDP_BRAM_INIT_CLEAR_EN
    localparam int INIT_EDGES = DEPTH + 1;
`else
    localparam int INIT_EDGES = 1;
`endif

    logic          clk    = 1'b0;
    logic          resetn = 1'b1;
    logic          ren    = 1'b0;
    logic [AW-1:0] raddr  = '0;
    logic [NB-1:0] wen    = '0;
    logic [AW-1:0] waddr  = '0;
    logic [DW-1:0] wdata  = '0;

    logic [2:0]    o_init;
    logic [2:0]    o_vld;
    logic [DW-1:0] o_data [3];

    always #5 clk = ~clk;

    sdp_bram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WRITE_FIRST(1)) u_l1 (
        .clk(clk), .resetn(resetn), .init_done(o_init[0]), .ren(ren), .raddr(raddr),
        .rvalid(o_vld[0]), .rdata(o_data[0]), .wen(wen), .waddr(waddr), .wdata(wdata));

    sdp_bram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_FIRST(0)) u_l2 (
        .clk(clk), .resetn(resetn), .init_done(o_init[1]), .ren(ren), .raddr(raddr),
        .rvalid(o_vld[1]), .rdata(o_data[1]), .wen(wen), .waddr(waddr), .wdata(wdata));

    sdp_bram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3), .WRITE_FIRST(1)) u_l3 (
        .clk(clk), .resetn(resetn), .init_done(o_init[2]), .ren(ren), .raddr(raddr),
        .rvalid(o_vld[2]), .rdata(o_data[2]), .wen(wen), .waddr(waddr), .wdata(wdata));

    // Reference model: one entry per edge holding what a read issued there returns
    typedef struct {
        bit            v;
        logic [DW-1:0] nw;
        logic [DW-1:0] ow;
    } rd_t;

    rd_t           hist [$];
    logic [DW-1:0] mem [DEPTH];
    bit            m_init;
    int            relcnt;
    bit            exp_v [3];
    logic [DW-1:0] exp_d [3];
    int            lat [3] = '{1, 2, 3};
    bit            wf  [3] = '{1'b1, 1'b0, 1'b1};
    int            n_err = 0;
    int            n_chk = 0;

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        rd_t e;
        e = '{1'b0, '0, '0};
        m_init = 1'b0;
        relcnt = 0;
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(e);
        for (int d = 0; d < 3; d++) begin
            exp_v[d] = 1'b0;
            exp_d[d] = '0;
        end
    endtask

    task automatic model_edge();
        rd_t e;
        rd_t h;
        e = '{1'b0, '0, '0};
        if (!resetn) begin
            hist.push_back(e);
            while (hist.size() > 4) void'(hist.pop_front());
            return;
        end
        if (m_init && ren) begin
            e.v  = 1'b1;
            e.ow = mem[raddr];
            e.nw = e.ow;
            if (raddr == waddr) begin
                for (int b = 0; b < NB; b++)
                    if (wen[b]) e.nw[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        if (m_init) begin
            for (int b = 0; b < NB; b++)
                if (wen[b]) mem[waddr][8*b +: 8] = wdata[8*b +: 8];
        end
        hist.push_back(e);
        while (hist.size() > 4) void'(hist.pop_front());
        for (int d = 0; d < 3; d++) begin
            h = hist[hist.size() - lat[d]];
            exp_v[d] = h.v;
            if (h.v) exp_d[d] = wf[d] ? h.nw : h.ow;
        end
        relcnt++;
        if (relcnt == INIT_EDGES) begin
            m_init = 1'b1;
`ifdef SDP_BRAM_INIT_CLEAR_EN
            for (int a = 0; a < DEPTH; a++) mem[a] = '0;
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s.init_l%0d", tag, lat[d]), DW'(o_init[d]), DW'(m_init));
            chk($sformatf("%s.vld_l%0d", tag, lat[d]), DW'(o_vld[d]), DW'(exp_v[d]));
            chk($sformatf("%s.data_l%0d", tag, lat[d]), o_data[d], exp_d[d]);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outs(tag);
    endtask

    task automatic rnd_in();
        ren   = 1'($urandom_range(0, 1));
        raddr = AW'($urandom);
        wen   = NB'($urandom);
        waddr = AW'($urandom);
        wdata = rnd_word();
    endtask

    task automatic idle();
        rnd_in();
        ren = 1'b0;
        wen = '0;
    endtask

    task automatic rst_assert(input int ncyc);
        rnd_in();
        resetn = 1'b0;
        #1;
        model_reset();
        check_outs("rst");
        repeat (ncyc) begin
            rnd_in();
            step("rst");
        end
        resetn = 1'b1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d, input string tag);
        ren = 1'b0; wen = be; waddr = a; wdata = d;
        step(tag);
    endtask

    task automatic rd(input logic [AW-1:0] a, input string tag);
        ren = 1'b1; raddr = a; wen = '0;
        step(tag);
    endtask

    initial begin
        #2;
        rst_assert(5);
        repeat (INIT_EDGES + 1) begin idle(); step("init"); end

        for (int a = 0; a < DEPTH; a++) wr(AW'(a), '1, rnd_word(), "fill");

        wr(4'd3, '1, {16{8'hA5}}, "wr3");
        rd(4'd3, "rd3");
        repeat (3) begin idle(); step("rd3"); end

        wr(4'd5, '1, {16{8'h11}}, "merge");
        wr(4'd5, 16'h000F, {16{8'hFF}}, "merge");
        rd(4'd5, "merge");
        repeat (3) begin idle(); step("merge"); end

        wr(4'd7, '1, '0, "coll");
        ren = 1'b1; raddr = 4'd7; wen = '1; waddr = 4'd7; wdata = {16{8'h5A}};
        step("coll");
        rd(4'd7, "coll");
        repeat (3) begin idle(); step("coll"); end

        for (int a = 0; a < 8; a++) rd(AW'(a), "b2b");
        repeat (3) begin idle(); step("b2b"); end

        repeat (400) begin
            rnd_in();
            ren = ($urandom % 4) != 0;
            if ($urandom % 3 == 0) waddr = raddr;
            case ($urandom % 4)
                0:       wen = '0;
                1:       wen = '1;
                default: wen = NB'($urandom);
            endcase
            step("rnd");
        end

        rd(4'd2, "mid");
        rd(4'd4, "mid");
        rst_assert(3);
        repeat (INIT_EDGES + 1) begin idle(); step("reinit"); end
        for (int a = 0; a < DEPTH; a++) rd(AW'(a), "post");
        repeat (3) begin idle(); step("post"); end

        rst_assert(2);
        repeat (10) begin idle(); step("sweep"); end
        rst_assert(2);
        repeat (INIT_EDGES + 1) begin idle(); step("rst2"); end
        repeat (40) begin
            rnd_in();
            step("tail");
        end
        repeat (3) begin idle(); step("tail"); end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
